// File: rtl/sequential_divider_if.sv
`default_nettype none
// ============================================================================
//  Module  : sequential_divider_if
//  Brief   : Operand/result handshake bundle shared by the iterative divider.
//  Revision: 1.0  initial release
// ============================================================================
interface sequential_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/sequential_divider.sv
`default_nettype none
// ============================================================================
//  Module  : sequential_divider
//  Brief   : Radix-2 restoring divider, one quotient bit per clock, signed or
//            unsigned, start/busy/done handshake.
//  Revision: 1.0  initial release
// ============================================================================
module sequential_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    sequential_divider_if.slave    bus
);

    localparam int              CW           = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   C_COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]   C_COUNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] C_ZERO      = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_load;
    logic              w_step;
    logic              w_finish;
    logic              w_busy;

    logic [WIDTH-1:0]  r_rem;
    logic [WIDTH-1:0]  r_quo;
    logic [WIDTH-1:0]  r_dvs;
    logic [WIDTH-1:0]  r_dvd_raw;
    logic [CW-1:0]     r_count;
    logic              r_q_neg;
    logic              r_r_neg;
    logic              r_dvz;

    logic [WIDTH-1:0]  r_quotient;
    logic [WIDTH-1:0]  r_remainder;
    logic              r_div_by_zero;
    logic              r_done;

    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [WIDTH-1:0]  w_dvd_mag;
    logic [WIDTH-1:0]  w_dvs_mag;
    logic [WIDTH:0]    w_shifted;
    logic [WIDTH:0]    w_trial;
    logic              w_trial_ok;

    assign w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    // MIN magnitude 2^(WIDTH-1) still fits as an unsigned WIDTH-bit value
    assign w_dvd_mag = w_dvd_neg ? (C_ZERO - bus.dividend) : bus.dividend;
    assign w_dvs_mag = w_dvs_neg ? (C_ZERO - bus.divisor)  : bus.divisor;

    assign w_shifted  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shifted - {1'b0, r_dvs};
    assign w_trial_ok = ~w_trial[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_count == C_COUNT_ONE) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_busy       = 1'b1;
                w_finish     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_dvd_raw <= '0;
            r_count   <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_dvz     <= 1'b0;
        end else if (w_load) begin
            r_rem     <= '0;
            r_quo     <= w_dvd_mag;
            r_dvs     <= w_dvs_mag;
            r_dvd_raw <= bus.dividend;
            r_count   <= C_COUNT_INIT;
            r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg   <= w_dvd_neg;
            r_dvz     <= (bus.divisor == C_ZERO);
        end else if (w_step) begin
            // Restoring step: keep the shifted remainder when the trial underflows
            r_rem   <= w_trial_ok ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
            r_quo   <= {r_quo[WIDTH-2:0], w_trial_ok};
            r_count <= r_count - C_COUNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                // Division by zero reports all-ones and the untouched dividend
                r_quotient    <= r_dvz ? '1 : (r_q_neg ? (C_ZERO - r_quo) : r_quo);
                r_remainder   <= r_dvz ? r_dvd_raw : (r_r_neg ? (C_ZERO - r_rem) : r_rem);
                r_div_by_zero <= r_dvz;
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_sequential_divider.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sequential_divider
//  Brief   : Self-checking bench for sequential_divider (WIDTH = 32).
//  Revision: 1.0  initial release
// ============================================================================
module tb_sequential_divider;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sequential_divider_if #(.WIDTH(W)) bus();

    sequential_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        nm;
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Truncating division from plain integer arithmetic
    function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz);
        longint sa, sb, tq, tr;
        dz = (b == '0);
        if (dz) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[W-1:0];
            r  = tr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 32'h8000_0000;
            2:       v = '1;
            3:       v = W'($urandom_range(0, 15));
            4:       v = 32'd0 - W'($urandom_range(1, 15));
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Called at a falling edge; returns at the falling edge after the done cycle
    task automatic do_op(input string nm, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input logic edz, input int repulse_at);
        logic [W-1:0] pq, pr;
        int           lat;
        bit           busy_ok, hold_ok;
        pq = bus.quotient;
        pr = bus.remainder;
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.is_signed = ~s;
        bus.dividend  = ~a;
        bus.divisor   = b ^ 32'h0000_0005;
        busy_ok = bus.busy && !bus.done;
        hold_ok = 1'b1;
        lat     = -1;
        for (int k = 1; k <= LAT + 5; k++) begin
            if (k == repulse_at) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd1000;
                bus.divisor  = 32'd3;
            end
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.quotient !== pq || bus.remainder !== pr) hold_ok = 1'b0;
        end
        chk({nm, " latency"},   W'(lat), W'(LAT));
        chk({nm, " busy_span"}, W'(busy_ok), W'(1));
        chk({nm, " hold"},      W'(hold_ok), W'(1));
        chk({nm, " busy@done"}, W'(bus.busy), W'(0));
        chk({nm, " quotient"},  bus.quotient, eq);
        chk({nm, " remainder"}, bus.remainder, er);
        chk({nm, " dbz"},       W'(bus.div_by_zero), W'(edz));
        @(negedge clk);
        chk({nm, " done_pulse"}, W'(bus.done), W'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, rq, rr;
        logic         rs, rdz;
        int           lat1, lat2;
        bit           no_done;

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        vecs.push_back('{"s_100_7",      1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0});
        vecs.push_back('{"u_ffff_2",     1'b0, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 32'd1,         1'b0});
        vecs.push_back('{"s_m100_7",     1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"s_100_m7",     1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0});
        vecs.push_back('{"s_m100_m7",    1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"u_ff9c_7",     1'b0, 32'hFFFF_FF9C, 32'd7,         32'h2492_4916, 32'd2,         1'b0});
        vecs.push_back('{"s_5_0",        1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1});
        vecs.push_back('{"s_clear_dbz",  1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0});
        vecs.push_back('{"s_min_m1",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0});
        vecs.push_back('{"s_0_9",        1'b1, 32'd0,         32'd9,         32'd0,         32'd0,         1'b0});
        vecs.push_back('{"s_m5_0",       1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1});
        vecs.push_back('{"u_7_100",      1'b0, 32'd7,         32'd100,       32'd0,         32'd7,         1'b0});
        vecs.push_back('{"s_min_1",      1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0});
        vecs.push_back('{"u_min_m1",     1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0});

        // Reset state
        #12;
        chk("rst busy",      W'(bus.busy), W'(0));
        chk("rst done",      W'(bus.done), W'(0));
        chk("rst quotient",  bus.quotient, '0);
        chk("rst remainder", bus.remainder, '0);
        chk("rst dbz",       W'(bus.div_by_zero), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].nm, vecs[i].s, vecs[i].a, vecs[i].b,
                  vecs[i].q, vecs[i].r, vecs[i].dz, -1);
        end

        // Start re-pulsed while busy must not disturb the running divide
        do_op("repulse", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10);

        // Start held high through the done cycle chains a second operation
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.dividend = 32'd1000; bus.divisor = 32'd3;
        lat1 = -1;
        for (int k = 1; k <= LAT + 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat1 = k;
                break;
            end
        end
        chk("chain first latency",   W'(lat1), W'(LAT));
        chk("chain first quotient",  bus.quotient, 32'd14);
        chk("chain first remainder", bus.remainder, 32'd2);
        lat2 = -1;
        for (int k = 1; k <= LAT + 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                lat2 = k;
                break;
            end
        end
        chk("chain second spacing",   W'(lat2), W'(LAT + 1));
        chk("chain second quotient",  bus.quotient, 32'd333);
        chk("chain second remainder", bus.remainder, 32'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy",      W'(bus.busy), W'(0));
        chk("abort done",      W'(bus.done), W'(0));
        chk("abort quotient",  bus.quotient, '0);
        chk("abort remainder", bus.remainder, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        no_done = 1'b1;
        for (int k = 0; k < LAT + 5; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) no_done = 1'b0;
        end
        chk("abort no_done", W'(no_done), W'(1));
        do_op("after_reset", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, -1);

        // Randomised operands against the reference model
        for (int i = 0; i < 1500; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = pick_operand();
            rb = pick_operand();
            ref_div(rs, ra, rb, rq, rr, rdz);
            do_op("rand", rs, ra, rb, rq, rr, rdz, -1);
            chk("rand identity", bus.quotient * rb + bus.remainder, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
